// File: rtl/spi_pwm_controller_if.sv
// SPI mode-0 bus bundle between an external master and the PWM controller.
// The master drives sclk/mosi/cs_n and the controller returns miso.
interface spi_pwm_controller_if;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs_n;
   logic spi_miso;

   modport master (
      output spi_sclk,
      output spi_mosi,
      output spi_cs_n,
      input  spi_miso
   );

   modport slave (
      input  spi_sclk,
      input  spi_mosi,
      input  spi_cs_n,
      output spi_miso
   );
endinterface

// File: rtl/spi_pwm_controller.sv
// SPI-programmed multi-channel PWM generator: a 16-bit SPI register interface
// sampled in the clk domain, a prescaled wrap counter and per-channel duty shadows.
module spi_pwm_controller #(
   parameter int unsigned NUM_CH = 16,
   parameter int unsigned DUTY_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   spi_pwm_controller_if.slave spi,
   output logic [NUM_CH-1:0]   pwm_out,
   output logic                period_start
);

   localparam logic [DUTY_W-1:0] CNT_LAST = {{(DUTY_W-1){1'b1}}, 1'b0};
   localparam logic [DUTY_W-1:0] CNT_ONE  = {{(DUTY_W-1){1'b0}}, 1'b1};
   localparam logic [15:0]       CH_MASK  = 16'((33'd1 << NUM_CH) - 33'd1);

   typedef enum logic [0:0] {StIdle, StFrame} frame_state_e;

   // Synchronisers: index 1 is the synchronised value, index 2 its previous sample.
   logic [2:0] sclk_sync_q;
   logic [2:0] cs_sync_q;
   logic [1:0] mosi_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], spi.spi_sclk};
         cs_sync_q   <= {cs_sync_q[1:0], spi.spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
      end
   end

   logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
   assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
   assign mosi_bit  = mosi_sync_q[1];

   // Register file
   logic [15:0]       out_en_q;
   logic [15:0]       pwm_en_q;
   logic [7:0]        prescale_q;
   logic              frame_err_q;
   logic [DUTY_W-1:0] duty_q   [NUM_CH];
   logic [DUTY_W-1:0] shadow_q [NUM_CH];

   // Frame receiver
   frame_state_e state_q;
   logic [4:0]   bit_cnt_q;
   logic [15:0]  shift_q;
   logic [7:0]   rd_shift_q;
   logic         is_read_q;
   logic         miso_q;

   logic [6:0] rd_addr;
   logic [7:0] rd_value;

   // Address as it will stand once the 8th bit is shifted in.
   assign rd_addr = {shift_q[5:0], mosi_bit};

   always_comb begin
      rd_value = '0;
      unique case (rd_addr)
         7'h00:   rd_value = out_en_q[7:0];
         7'h01:   rd_value = out_en_q[15:8];
         7'h02:   rd_value = pwm_en_q[7:0];
         7'h03:   rd_value = pwm_en_q[15:8];
         7'h04:   rd_value = prescale_q;
         7'h05:   rd_value = {7'd0, frame_err_q};
         default: begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
               if (rd_addr == 7'(16 + ch)) rd_value = 8'(duty_q[ch]);
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         rd_shift_q <= '0;
         is_read_q  <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         if (cs_fall) begin
            state_q   <= StFrame;
            bit_cnt_q <= '0;
            is_read_q <= 1'b0;
            miso_q    <= 1'b0;
         end else if (state_q == StFrame) begin
            if (cs_rise) begin
               state_q <= StIdle;
            end else begin
               if (sclk_rise) begin
                  shift_q <= {shift_q[14:0], mosi_bit};
                  if (bit_cnt_q < 5'd17) bit_cnt_q <= bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd7) begin
                     is_read_q  <= ~shift_q[6];
                     rd_shift_q <= rd_value;
                  end
               end
               // Data phase: bit counts 8..15 cover the eight falling edges.
               if (sclk_fall && is_read_q && bit_cnt_q[4:3] == 2'b01) begin
                  miso_q     <= rd_shift_q[7];
                  rd_shift_q <= {rd_shift_q[6:0], 1'b0};
               end
            end
         end
         if (cs_sync_q[1]) miso_q <= 1'b0;
      end
   end

   assign spi.spi_miso = miso_q & ~spi.spi_cs_n;

   logic       frame_end, commit_wr, frame_err_set, prescale_wr;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;

   assign frame_end     = (state_q == StFrame) && cs_rise;
   assign commit_wr     = frame_end && (bit_cnt_q == 5'd16) && shift_q[15];
   assign frame_err_set = frame_end && (bit_cnt_q != 5'd16);
   assign wr_addr       = shift_q[14:8];
   assign wr_data       = shift_q[7:0];
   assign prescale_wr   = commit_wr && (wr_addr == 7'h04);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_en_q    <= '0;
         pwm_en_q    <= '0;
         prescale_q  <= '0;
         frame_err_q <= 1'b0;
         for (int ch = 0; ch < NUM_CH; ch++) duty_q[ch] <= '0;
      end else begin
         if (commit_wr) begin
            unique case (wr_addr)
               7'h00:   out_en_q[7:0]  <= wr_data & CH_MASK[7:0];
               7'h01:   out_en_q[15:8] <= wr_data & CH_MASK[15:8];
               7'h02:   pwm_en_q[7:0]  <= wr_data & CH_MASK[7:0];
               7'h03:   pwm_en_q[15:8] <= wr_data & CH_MASK[15:8];
               7'h04:   prescale_q     <= wr_data;
               default: begin
                  for (int ch = 0; ch < NUM_CH; ch++) begin
                     if (wr_addr == 7'(16 + ch)) duty_q[ch] <= wr_data[DUTY_W-1:0];
                  end
               end
            endcase
         end
         // A hardware error outranks a simultaneous write-1-to-clear.
         if (frame_err_set) begin
            frame_err_q <= 1'b1;
         end else if (commit_wr && wr_addr == 7'h05 && wr_data[0]) begin
            frame_err_q <= 1'b0;
         end
      end
   end

   // Prescaler and period counter
   logic [7:0]        presc_cnt_q;
   logic [DUTY_W-1:0] cnt_q;
   logic              period_start_q;
   logic              tick, wrap;

   assign tick = (presc_cnt_q == prescale_q);
   assign wrap = tick && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt_q    <= '0;
         cnt_q          <= '0;
         period_start_q <= 1'b0;
         for (int ch = 0; ch < NUM_CH; ch++) shadow_q[ch] <= '0;
      end else begin
         if (prescale_wr || tick) presc_cnt_q <= '0;
         else                     presc_cnt_q <= presc_cnt_q + 8'd1;

         if (tick) cnt_q <= wrap ? '0 : cnt_q + CNT_ONE;
         period_start_q <= wrap;

         if (wrap) begin
            for (int ch = 0; ch < NUM_CH; ch++) shadow_q[ch] <= duty_q[ch];
         end
      end
   end

   assign period_start = period_start_q;

   // Enables act directly on the output stage so they never wait for a wrap.
   logic [NUM_CH-1:0] pwm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_q <= '0;
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            pwm_q[ch] <= out_en_q[ch] & (~pwm_en_q[ch] | (cnt_q < shadow_q[ch]));
         end
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_spi_pwm_controller.sv
// Randomised bench for spi_pwm_controller: SPI frames driven through the bus
// interface, register reads and PWM waveforms checked against a register/arithmetic model.
module tb_spi_pwm_controller;
   localparam int NUM_CH = 16;
   localparam int DUTY_W = 8;
   localparam int HALF   = 8;
   localparam int MAXV   = (1 << DUTY_W) - 1;
   localparam int LIMIT  = 20000;

   logic              clk = 1'b0;
   logic              rst;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_start;

   spi_pwm_controller_if spi_bus ();

   spi_pwm_controller #(
      .NUM_CH(NUM_CH),
      .DUTY_W(DUTY_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .spi          (spi_bus.slave),
      .pwm_out      (pwm_out),
      .period_start (period_start)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] mdl [128];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void mdl_reset();
      for (int i = 0; i < 128; i++) mdl[i] = 8'h00;
   endfunction

   function automatic void mdl_write(input int a, input int d);
      int mask;
      mask = (1 << NUM_CH) - 1;
      if (a <= 1)                        mdl[a] = 8'(d & (mask >> (8 * a)));
      else if (a <= 3)                   mdl[a] = 8'(d & (mask >> (8 * (a - 2))));
      else if (a == 4)                   mdl[a] = 8'(d);
      else if (a == 5)                   begin if (d % 2 == 1) mdl[5] = 8'h00; end
      else if (a >= 16 && a < 16 + NUM_CH) mdl[a] = 8'(d & MAXV);
   endfunction

   // Channels enabled with PWM disabled sit at a constant 1.
   function automatic logic [15:0] static_out();
      return {mdl[1], mdl[0]} & ~{mdl[3], mdl[2]};
   endfunction

   task automatic spi_frame(input int nbits, input logic [15:0] word, output logic [7:0] rdata);
      rdata = 8'h00;
      @(negedge clk);
      spi_bus.spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         spi_bus.spi_mosi = word[15-i];
         repeat (HALF) @(negedge clk);
         if (i >= 8) rdata = {rdata[6:0], spi_bus.spi_miso};
         spi_bus.spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_bus.spi_sclk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      spi_bus.spi_cs_n = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic spi_write(input int a, input int d);
      logic [7:0] r;
      spi_frame(16, {1'b1, 7'(a), 8'(d)}, r);
      mdl_write(a, d);
   endtask

   task automatic spi_read(input int a, output logic [7:0] r);
      spi_frame(16, {1'b0, 7'(a), 8'h00}, r);
   endtask

   task automatic wait_ps();
      int n;
      n = 0;
      @(negedge clk);
      while (!period_start && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) check_eq("period_start_timeout", 32'(period_start), 32'd1);
   endtask

   // Called on a negedge where period_start is high; returns on the next one.
   task automatic measure(input int ch, output int len, output int highs);
      len   = 0;
      highs = 0;
      do begin
         highs += int'(pwm_out[ch]);
         len++;
         @(negedge clk);
      end while (!period_start && len < LIMIT);
   endtask

   initial begin
      logic [7:0] rd;
      int len1, hi1, len2, hi2, p, d1, d2, exp_hi1, exp_hi2, exp_len;
      int a, d, nb;
      int addrs [7];

      rst = 1'b1;
      spi_bus.spi_sclk = 1'b0;
      spi_bus.spi_mosi = 1'b0;
      spi_bus.spi_cs_n = 1'b1;
      mdl_reset();
      repeat (3) @(negedge clk);
      check_eq("reset_pwm", 32'(pwm_out), 32'd0);
      check_eq("reset_ps", 32'(period_start), 32'd0);
      check_eq("reset_miso", 32'(spi_bus.spi_miso), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Static enable: channel 0 on, PWM off
      spi_write(0, 8'h01);
      spi_write(2, 8'h00);
      check_eq("static_en_pwm", 32'(pwm_out), 32'(static_out()));
      spi_read(0, rd);
      check_eq("rd_out_en0", 32'(rd), 32'(mdl[0]));
      check_eq("miso_idle", 32'(spi_bus.spi_miso), 32'd0);

      // 0x80 duty, no prescale
      spi_write(2, 8'h01);
      spi_write(8'h10, 8'h80);
      spi_write(4, 8'h00);
      wait_ps();
      wait_ps();
      measure(0, len1, hi1);
      check_eq("duty80_len", 32'(len1), 32'(MAXV * (mdl[4] + 1)));
      check_eq("duty80_high", 32'(hi1), 32'(mdl[8'h10] * (mdl[4] + 1)));

      // Mid-period duty rewrite, random prescale and duties
      p  = $urandom_range(2, 4);
      d1 = $urandom_range(20, 230);
      d2 = $urandom_range(10, 240);
      if (d2 == d1) d2 = d1 + 7;
      spi_write(4, p);
      spi_write(8'h10, d1);
      wait_ps();
      exp_len = MAXV * (mdl[4] + 1);
      exp_hi1 = mdl[8'h10] * (mdl[4] + 1);
      exp_hi2 = d2 * (mdl[4] + 1);
      fork
         measure(0, len1, hi1);
         begin
            repeat (20) @(negedge clk);
            spi_write(8'h10, d2);
         end
      join
      measure(0, len2, hi2);
      check_eq("midper_len1", 32'(len1), 32'(exp_len));
      check_eq("midper_high1", 32'(hi1), 32'(exp_hi1));
      check_eq("midper_len2", 32'(len2), 32'(exp_len));
      check_eq("midper_high2", 32'(hi2), 32'(exp_hi2));

      // Channel 3 at full and zero duty across three periods each
      spi_write(4, 0);
      spi_write(0, 8'h09);
      spi_write(2, 8'h09);
      for (int k = 0; k < 2; k++) begin
         spi_write(8'h13, (k == 0) ? 8'hFF : 8'h00);
         wait_ps();
         wait_ps();
         for (int n = 0; n < 3; n++) begin
            measure(3, len1, hi1);
            check_eq("ch3_len", 32'(len1), 32'(MAXV));
            check_eq("ch3_high", 32'(hi1), 32'(mdl[8'h13] * len1 / MAXV));
         end
      end

      // Truncated frame and STATUS write-1-to-clear
      spi_frame(12, {1'b1, 7'h04, 8'hA5}, rd);
      mdl[5] = 8'h01;
      spi_read(4, rd);
      check_eq("short_no_write", 32'(rd), 32'(mdl[4]));
      spi_read(5, rd);
      check_eq("status_err", 32'(rd), 32'(mdl[5]));
      spi_write(5, 8'h01);
      spi_read(5, rd);
      check_eq("status_clr", 32'(rd), 32'(mdl[5]));

      // Random register traffic including short frames and unmapped addresses
      for (int i = 0; i < 18; i++) begin
         if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 127);
         else begin
            a = $urandom_range(0, 5 + NUM_CH);
            if (a > 5) a = a + 10;
         end
         d = $urandom_range(0, 255);
         if ($urandom_range(0, 4) == 0) begin
            nb = $urandom_range(1, 15);
            spi_frame(nb, {1'b1, 7'(a), 8'(d)}, rd);
            mdl[5] = 8'h01;
         end else begin
            spi_write(a, d);
         end
         spi_read(a, rd);
         check_eq($sformatf("rand_rd_%0h", a), 32'(rd), 32'(mdl[a]));
      end

      // Reset mid-frame and mid-period
      spi_write(0, 8'h01);
      spi_write(1, 8'h00);
      spi_write(2, 8'h00);
      spi_write(3, 8'h00);
      check_eq("pre_rst_pwm", 32'(pwm_out), 32'(static_out()));
      @(negedge clk);
      spi_bus.spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         spi_bus.spi_mosi = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_bus.spi_sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         spi_bus.spi_sclk = 1'b0;
      end
      rst = 1'b1;
      mdl_reset();
      #1;
      check_eq("rst_pwm", 32'(pwm_out), 32'd0);
      check_eq("rst_ps", 32'(period_start), 32'd0);
      check_eq("rst_miso", 32'(spi_bus.spi_miso), 32'd0);
      repeat (3) @(negedge clk);
      spi_bus.spi_cs_n = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      addrs = '{0, 1, 2, 3, 4, 5, 16};
      foreach (addrs[i]) begin
         spi_read(addrs[i], rd);
         check_eq($sformatf("post_rst_rd_%0h", addrs[i]), 32'(rd), 32'(mdl[addrs[i]]));
      end
      spi_write(4, 8'h55);
      spi_read(4, rd);
      check_eq("post_rst_commit", 32'(rd), 32'(mdl[4]));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1);
   end

endmodule
